// File: rtl/idma_stream_sched_pkg.sv
// Shared types for the iDMA stream scheduler: descriptor bundle,
// stream index type and the zero-skipping transfer ID increment.
package idma_stream_sched_pkg;

   localparam int MaxAddrWidth = 64;
   localparam int MaxIdWidth   = 64;
   localparam int MaxStreams   = 16;

   typedef struct packed {
      logic [MaxAddrWidth-1:0] dst;
      logic [MaxAddrWidth-1:0] src;
      logic [MaxAddrWidth-1:0] len;
   } desc_t;

   typedef logic [$clog2(MaxStreams)-1:0] stream_idx_t;

   // ID 0 is reserved as "nothing done yet", so the
   // increment wraps from all-ones (of width) to 1.
   function automatic logic [MaxIdWidth-1:0] id_inc(
      input logic [MaxIdWidth-1:0] id,
      input int                    width
   );
      logic [MaxIdWidth-1:0] ones;
      ones = {MaxIdWidth{1'b1}} >> (MaxIdWidth - width);
      return (id == ones) ? MaxIdWidth'(1) : id + MaxIdWidth'(1);
   endfunction

endpackage

// File: rtl/idma_stream_rr_arb.sv
// Round-robin arbiter over N request lines; pointer moves one past
// the granted line when adv is high. Ports: clk, rst, req, adv, gnt, idx.
module idma_stream_rr_arb
   import idma_stream_sched_pkg::*;
#(
   parameter int N = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [N-1:0] req,
   input  logic        adv,
   output logic [N-1:0] gnt,
   output stream_idx_t idx
);

   stream_idx_t ptr;

   // Lowest request overall, overridden by the lowest one at or
   // above the pointer when such a request exists.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) idx = stream_idx_t'(i);
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i] && (i >= int'(ptr))) idx = stream_idx_t'(i);
      end
      gnt = '0;
      if (|req) gnt[idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
      end else if (adv && (|req)) begin
         ptr <= (int'(idx) == N - 1) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/idma_stream_sched.sv
// Multi-stream iDMA launch scheduler: arbitrates per-stream launches onto
// one registered backend request and tracks per-stream IDs/outstanding.
// Ports: clk_i, rst_i, launch_* (per stream), be_req_* (backend request),
// be_rsp_* (completions), next_id_o, done_id_o, busy_o.
// Macro IDMA_STREAM_SCHED_ERR_EN adds be_rsp_error_i, err_clear_i, err_o.
module idma_stream_sched
   import idma_stream_sched_pkg::*;
#(
   parameter int NumStreams     = 16,
   parameter int AddrWidth      = 64,
   parameter int IdWidth        = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NumStreams-1:0]           launch_valid_i,
   output logic [NumStreams-1:0]           launch_ready_o,
   input  logic [NumStreams*AddrWidth-1:0] launch_dst_i,
   input  logic [NumStreams*AddrWidth-1:0] launch_src_i,
   input  logic [NumStreams*AddrWidth-1:0] launch_len_i,
   output logic [NumStreams*IdWidth-1:0]   launch_id_o,
   output logic                            be_req_valid_o,
   input  logic                            be_req_ready_i,
   output logic [AddrWidth-1:0]            be_req_dst_o,
   output logic [AddrWidth-1:0]            be_req_src_o,
   output logic [AddrWidth-1:0]            be_req_len_o,
   output logic [$clog2(NumStreams)-1:0]   be_req_stream_o,
   input  logic                            be_rsp_valid_i,
   input  logic [$clog2(NumStreams)-1:0]   be_rsp_stream_i,
`ifdef IDMA_STREAM_SCHED_ERR_EN
   input  logic                            be_rsp_error_i,
   input  logic [NumStreams-1:0]           err_clear_i,
   output logic [NumStreams-1:0]           err_o,
`endif
   output logic [NumStreams*IdWidth-1:0]   next_id_o,
   output logic [NumStreams*IdWidth-1:0]   done_id_o,
   output logic [NumStreams-1:0]           busy_o
);

   localparam int SW = $clog2(NumStreams);

   desc_t                lane [NumStreams];
   logic [IdWidth-1:0]   next_id [NumStreams];
   logic [IdWidth-1:0]   done_id [NumStreams];
   logic [3:0]           outst [NumStreams];
   logic [NumStreams-1:0] elig, gnt, rsp, blocked;
   stream_idx_t          sel, stream_q;
   desc_t                sel_desc, req_q;
   logic                 valid_q, drain, can_load, zero;

   function automatic logic [IdWidth-1:0] bump(input logic [IdWidth-1:0] v);
      return IdWidth'(id_inc(MaxIdWidth'(v), IdWidth));
   endfunction

   for (genvar s = 0; s < NumStreams; s++) begin : g_s
      assign lane[s] = '{
         dst: MaxAddrWidth'(launch_dst_i[s*AddrWidth +: AddrWidth]),
         src: MaxAddrWidth'(launch_src_i[s*AddrWidth +: AddrWidth]),
         len: MaxAddrWidth'(launch_len_i[s*AddrWidth +: AddrWidth])
      };
      assign elig[s] = launch_valid_i[s] & ~blocked[s]
                     & (outst[s] < 4'(MaxOutstanding));
      // A response with nothing in flight is dropped.
      assign rsp[s] = be_rsp_valid_i & (be_rsp_stream_i == SW'(s))
                    & (outst[s] != '0);
      assign busy_o[s] = (outst[s] != '0)
                       | (valid_q & (stream_q == stream_idx_t'(s)));
      assign next_id_o[s*IdWidth +: IdWidth]   = next_id[s];
      assign launch_id_o[s*IdWidth +: IdWidth] = next_id[s];
      assign done_id_o[s*IdWidth +: IdWidth]   = done_id[s];
   end

   assign drain    = valid_q & be_req_ready_i;
   assign can_load = ~valid_q | drain;

   idma_stream_rr_arb #(.N(NumStreams)) u_arb (
      .clk (clk_i),
      .rst (rst_i),
      .req (elig),
      .adv (can_load),
      .gnt (gnt),
      .idx (sel)
   );

   assign launch_ready_o = gnt & {NumStreams{can_load & ~rst_i}};
   assign sel_desc       = lane[sel];
   assign zero           = (sel_desc.len == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q  <= 1'b0;
         req_q    <= '0;
         stream_q <= '0;
      end else if ((|launch_ready_o) && !zero) begin
         valid_q  <= 1'b1;
         req_q    <= sel_desc;
         stream_q <= sel;
      end else if (drain) begin
         valid_q  <= 1'b0;
      end
   end

   assign be_req_valid_o  = valid_q;
   assign be_req_dst_o    = req_q.dst[AddrWidth-1:0];
   assign be_req_src_o    = req_q.src[AddrWidth-1:0];
   assign be_req_len_o    = req_q.len[AddrWidth-1:0];
   assign be_req_stream_o = stream_q[SW-1:0];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int s = 0; s < NumStreams; s++) begin
            next_id[s] <= IdWidth'(1);
            done_id[s] <= '0;
            outst[s]   <= '0;
         end
      end else begin
         for (int s = 0; s < NumStreams; s++) begin
            if (launch_ready_o[s]) next_id[s] <= bump(next_id[s]);
            // Zero-length launches complete on acceptance.
            case ({launch_ready_o[s] & zero, rsp[s]})
               2'b11:   done_id[s] <= bump(bump(done_id[s]));
               2'b10,
               2'b01:   done_id[s] <= bump(done_id[s]);
               default: done_id[s] <= done_id[s];
            endcase
            case ({launch_ready_o[s] & ~zero, rsp[s]})
               2'b10:   outst[s] <= outst[s] + 4'd1;
               2'b01:   outst[s] <= outst[s] - 4'd1;
               default: outst[s] <= outst[s];
            endcase
         end
      end
   end

`ifdef IDMA_STREAM_SCHED_ERR_EN
   logic [NumStreams-1:0] err_q;

   // Sticky error; a new error wins over a same-cycle clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_q <= '0;
      end else begin
         for (int s = 0; s < NumStreams; s++) begin
            if (rsp[s] && be_rsp_error_i) err_q[s] <= 1'b1;
            else if (err_clear_i[s])      err_q[s] <= 1'b0;
         end
      end
   end

   assign blocked = err_q;
   assign err_o   = err_q;
`else
   assign blocked = '0;
`endif

endmodule

// File: tb/tb_idma_stream_sched.sv
// Directed self-checking bench for idma_stream_sched, plus a narrow-ID
// instance for the ID wrap-around.
module tb_idma_stream_sched;

   logic          clk, rst;
   logic [15:0]   lv, lr, busy;
   logic [1023:0] dst, src, len;
   logic [511:0]  lid, nid, did;
   logic          bv, br, rv;
   logic [63:0]   bdst, bsrc, blen;
   logic [3:0]    bstr, rstr;

   logic [15:0]   w_lv, w_lr, w_busy;
   logic [1023:0] w_len;
   logic [31:0]   w_lid, w_nid, w_did;
   logic          w_bv;
   logic [63:0]   w_bdst, w_bsrc, w_blen;
   logic [3:0]    w_bstr;

`ifdef IDMA_STREAM_SCHED_ERR_EN
   logic          rerr;
   logic [15:0]   clr, err;
   logic [15:0]   w_err;
`endif

   int n_vec = 0;
   int n_err = 0;
   int cnt;
   int ord [6] = '{0, 1, 2, 0, 1, 2};

   idma_stream_sched dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .launch_valid_i  (lv),
      .launch_ready_o  (lr),
      .launch_dst_i    (dst),
      .launch_src_i    (src),
      .launch_len_i    (len),
      .launch_id_o     (lid),
      .be_req_valid_o  (bv),
      .be_req_ready_i  (br),
      .be_req_dst_o    (bdst),
      .be_req_src_o    (bsrc),
      .be_req_len_o    (blen),
      .be_req_stream_o (bstr),
      .be_rsp_valid_i  (rv),
      .be_rsp_stream_i (rstr),
`ifdef IDMA_STREAM_SCHED_ERR_EN
      .be_rsp_error_i  (rerr),
      .err_clear_i     (clr),
      .err_o           (err),
`endif
      .next_id_o       (nid),
      .done_id_o       (did),
      .busy_o          (busy)
   );

   idma_stream_sched #(.IdWidth(2)) u_wrap (
      .clk_i           (clk),
      .rst_i           (rst),
      .launch_valid_i  (w_lv),
      .launch_ready_o  (w_lr),
      .launch_dst_i    (dst),
      .launch_src_i    (src),
      .launch_len_i    (w_len),
      .launch_id_o     (w_lid),
      .be_req_valid_o  (w_bv),
      .be_req_ready_i  (1'b1),
      .be_req_dst_o    (w_bdst),
      .be_req_src_o    (w_bsrc),
      .be_req_len_o    (w_blen),
      .be_req_stream_o (w_bstr),
      .be_rsp_valid_i  (1'b0),
      .be_rsp_stream_i (4'd0),
`ifdef IDMA_STREAM_SCHED_ERR_EN
      .be_rsp_error_i  (1'b0),
      .err_clear_i     (16'h0),
      .err_o           (w_err),
`endif
      .next_id_o       (w_nid),
      .done_id_o       (w_did),
      .busy_o          (w_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input int s, input logic [63:0] d,
                         input logic [63:0] sr, input logic [63:0] l);
      lv[s] = 1'b1;
      dst[s*64 +: 64] = d;
      src[s*64 +: 64] = sr;
      len[s*64 +: 64] = l;
   endtask

   function automatic logic [31:0] nid_of(input int s);
      return nid[s*32 +: 32];
   endfunction

   function automatic logic [31:0] did_of(input int s);
      return did[s*32 +: 32];
   endfunction

   function automatic logic [31:0] lid_of(input int s);
      return lid[s*32 +: 32];
   endfunction

   initial begin
      rst = 1'b1; lv = '0; dst = '0; src = '0; len = '0;
      br = 1'b0; rv = 1'b0; rstr = '0;
      w_lv = '0; w_len = '0;
`ifdef IDMA_STREAM_SCHED_ERR_EN
      rerr = 1'b0; clr = '0;
`endif
      launch(3, 64'h1000, 64'h2000, 64'h40);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", bv, 0);
      chk("rst_ready", lr, 0);
      chk("rst_next_id", nid_of(3), 1);
      chk("rst_done_id", did_of(3), 0);
      chk("rst_busy", busy, 0);
      chk("rst_dst", bdst, 0);
`ifdef IDMA_STREAM_SCHED_ERR_EN
      chk("rst_err", err, 0);
`endif

      // single launch on stream 3
      rst = 1'b0;
      #1;
      chk("s3_ready", lr, 16'h0008);
      chk("s3_launch_id", lid_of(3), 1);
      tick;
      lv = '0;
      #1;
      chk("s3_valid", bv, 1);
      chk("s3_stream", bstr, 3);
      chk("s3_dst", bdst, 64'h1000);
      chk("s3_src", bsrc, 64'h2000);
      chk("s3_len", blen, 64'h40);
      chk("s3_next_id", nid_of(3), 2);
      chk("s3_busy", busy[3], 1);
      br = 1'b1;
      tick;
      chk("s3_drained", bv, 0);
      br = 1'b0;
      rv = 1'b1; rstr = 4'd3;
      tick;
      rv = 1'b0;
      #1;
      chk("s3_done_id", did_of(3), 1);
      chk("s3_idle", busy[3], 0);

      // round robin over streams 0,1,2
      launch(0, 64'h100, 64'h200, 64'h10);
      launch(1, 64'h110, 64'h210, 64'h10);
      launch(2, 64'h120, 64'h220, 64'h10);
      br = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         chk("rr_ready", lr, 64'(16'h1 << ord[i]));
         tick;
         chk("rr_stream", bstr, ord[i]);
      end
      lv = '0;
      tick;
      chk("rr_drain", bv, 0);

      // in-flight limit on stream 5
      launch(5, 64'h5000, 64'h6000, 64'h10);
      #1;
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (lr[5]) cnt++;
         tick;
      end
      chk("max_out_count", 64'(cnt), 4);
      chk("max_out_blocked", lr[5], 0);
      chk("max_out_next_id", nid_of(5), 5);
      rv = 1'b1; rstr = 4'd5;
      #1;
      chk("max_out_still_blocked", lr[5], 0);
      tick;
      rv = 1'b0;
      #1;
      chk("max_out_reopen", lr[5], 1);
      chk("max_out_done_id", did_of(5), 1);
      lv[5] = 1'b0;

      // zero-length launch on stream 7
      launch(7, 64'h0, 64'h0, 64'h0);
      #1;
      chk("zero_ready", lr, 16'h0080);
      tick;
      lv[7] = 1'b0;
      #1;
      chk("zero_no_req", bv, 0);
      chk("zero_next_id", nid_of(7), 2);
      chk("zero_done_id", did_of(7), 1);
      chk("zero_busy", busy[7], 0);

      // backend stall for 10 cycles
      br = 1'b0;
      launch(6, 64'hAAAA, 64'hBBBB, 64'h80);
      #1;
      tick;
      lv[6] = 1'b0;
      launch(8, 64'hC, 64'hD, 64'h8);
      #1;
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", bv, 1);
         chk("stall_dst", bdst, 64'hAAAA);
         chk("stall_src", bsrc, 64'hBBBB);
         chk("stall_len", blen, 64'h80);
         chk("stall_stream", bstr, 6);
         chk("stall_no_grant", lr, 0);
         tick;
      end
      br = 1'b1;
      #1;
      chk("stall_release_grant", lr, 16'h0100);
      tick;
      lv[8] = 1'b0;
      #1;
      chk("stall_next_stream", bstr, 8);
      chk("stall_next_dst", bdst, 64'hC);
      tick;
      chk("stall_drain", bv, 0);

      // same-cycle launch and response on stream 2 (2 in flight)
      launch(2, 64'h7000, 64'h7100, 64'h20);
      rv = 1'b1; rstr = 4'd2;
      #1;
      chk("same_ready", lr, 16'h0004);
      tick;
      lv[2] = 1'b0;
      #1;
      chk("same_next_id", nid_of(2), 4);
      chk("same_done_id", did_of(2), 1);
      chk("same_busy", busy[2], 1);
      tick;
      chk("same_rsp2_done", did_of(2), 2);
      chk("same_rsp2_busy", busy[2], 1);
      tick;
      chk("same_rsp3_done", did_of(2), 3);
      chk("same_rsp3_idle", busy[2], 0);
      tick;
      chk("rsp_ignored", did_of(2), 3);
      rv = 1'b0;

      // ID wrap on a 2-bit ID instance: 1,2,3,1
      w_lv[0] = 1'b1;
      #1;
      repeat (3) tick;
      chk("wrap_next_id", w_nid[1:0], 1);
      chk("wrap_done_id", w_did[1:0], 3);
      tick;
      chk("wrap_next_id2", w_nid[1:0], 2);
      chk("wrap_done_id2", w_did[1:0], 1);
      w_lv[0] = 1'b0;

`ifdef IDMA_STREAM_SCHED_ERR_EN
      // errored response on stream 4 blocks it until cleared
      launch(4, 64'h4000, 64'h4100, 64'h10);
      #1;
      tick;
      lv[4] = 1'b0;
      tick;
      rv = 1'b1; rstr = 4'd4; rerr = 1'b1;
      tick;
      rv = 1'b0; rerr = 1'b0;
      #1;
      chk("err_set", err[4], 1);
      chk("err_done_id", did_of(4), 1);
      lv[4] = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("err_blocked", lr[4], 0);
         tick;
      end
      clr[4] = 1'b1;
      tick;
      clr[4] = 1'b0;
      #1;
      chk("err_cleared", err[4], 0);
      chk("err_regrant", lr[4], 1);
      lv[4] = 1'b0;
      tick;
`endif

      // reset while a request is held
      br = 1'b0;
      launch(9, 64'h9000, 64'h9100, 64'h30);
      #1;
      tick;
      lv[9] = 1'b0;
      #1;
      chk("midrst_held", bv, 1);
      rst = 1'b1;
      #1;
      chk("midrst_valid", bv, 0);
      chk("midrst_next_id", nid_of(9), 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_dst", bdst, 0);
      tick;
      rst = 1'b0;
      rv = 1'b1; rstr = 4'd9;
      tick;
      rv = 1'b0;
      #1;
      chk("late_rsp_ignored", did_of(9), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
